// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared definitions for the register-dump UART transmitter: FSM states, index widths, ASCII codes.
// Used by reg_dump_uart_tx and uart_tx_byte; REG_DUMP_ASCII_EN selects the hex-text word format.
package reg_dump_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT
    } dump_state_t;

    localparam int BYTE_IDX_W = 4;
    localparam int BIT_IDX_W  = 3;

    localparam int BIN_BYTES_PER_WORD   = 4;
    localparam int ASCII_BYTES_PER_WORD = 10;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Upper-case hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ASCII_ZERO + {4'd0, nib}
                             : ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer datapath: baud counter, data-bit counter and shift register.
// The dump FSM owns the frame phase and passes it in as i_state; this block times and shifts.
module uart_tx_byte
    import reg_dump_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  dump_state_t i_state,
    input  logic [7:0]  i_data,
    input  logic        i_load,
    output logic        o_tx,
    output logic        o_bit_end,
    output logic        o_last_bit,
    output logic        o_byte_done
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_IDX_W-1:0] r_bit;
    logic [7:0]           r_shift;
    logic                 w_in_frame;

    assign w_in_frame  = (i_state == START_BIT) || (i_state == DATA_BITS) || (i_state == STOP_BIT);
    assign o_bit_end   = w_in_frame && (r_baud == BAUD_MAX);
    assign o_last_bit  = (r_bit == 3'd7);
    assign o_byte_done = o_bit_end && (i_state == STOP_BIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (i_load) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= i_data;
        end else if (w_in_frame) begin
            r_baud <= (r_baud == BAUD_MAX) ? '0 : r_baud + 1'b1;
            // The 3-bit counter wraps 7 -> 0 on the last data bit.
            if (o_bit_end && (i_state == DATA_BITS)) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    always_comb begin
        case (i_state)
            START_BIT: o_tx = 1'b0;
            DATA_BITS: o_tx = r_shift[0];
            default:   o_tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Dumps register-file entries FIRST_REG..LAST_REG over an 8N1 UART line, one word per LOAD.
// Default: 4 raw bytes per word, MSB first. Define REG_DUMP_ASCII_EN for 8 hex chars + CR LF.
module reg_dump_uart_tx
    import reg_dump_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
`ifdef REG_DUMP_ASCII_EN
    localparam int BYTES_PER_WORD = ASCII_BYTES_PER_WORD;
`else
    localparam int BYTES_PER_WORD = BIN_BYTES_PER_WORD;
`endif
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE  = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [3:0]            FIRST_ADDR = 4'(FIRST_REG);
    localparam logic [3:0]            LAST_ADDR  = 4'(LAST_REG);

    dump_state_t           r_state;
    dump_state_t           w_next_state;
    logic [3:0]            r_addr;
    logic [31:0]           r_shadow;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic                  r_done;

    logic                  w_bit_end;
    logic                  w_last_bit;
    logic                  w_byte_done;
    logic                  w_ser_load;
    logic [31:0]           w_load_word;
    logic [BYTE_IDX_W-1:0] w_load_idx;
    logic [7:0]            w_load_byte;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (start) w_next_state = LOAD;
            LOAD:      w_next_state = START_BIT;
            START_BIT: if (w_bit_end) w_next_state = DATA_BITS;
            DATA_BITS: if (w_bit_end && w_last_bit) w_next_state = STOP_BIT;
            STOP_BIT:  if (w_byte_done) w_next_state = (r_byte_idx == LAST_BYTE) ? NEXT : START_BIT;
            NEXT:      w_next_state = (r_addr < LAST_ADDR) ? LOAD : IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // The first byte of a word is loaded straight from rf_data while the shadow captures it.
    assign w_ser_load  = (r_state == LOAD) ||
                         ((r_state == STOP_BIT) && w_byte_done && (r_byte_idx != LAST_BYTE));
    assign w_load_word = (r_state == LOAD) ? rf_data : r_shadow;
    assign w_load_idx  = (r_state == LOAD) ? '0 : r_byte_idx + 1'b1;

    always_comb begin
        w_load_byte = 8'h00;
`ifdef REG_DUMP_ASCII_EN
        if (w_load_idx == 4'd8)
            w_load_byte = ASCII_CR;
        else if (w_load_idx == 4'd9)
            w_load_byte = ASCII_LF;
        else
            w_load_byte = hex_ascii(4'(w_load_word >> (6'd28 - 6'(w_load_idx) * 6'd4)));
`else
        w_load_byte = 8'(w_load_word >> (6'd24 - 6'(w_load_idx) * 6'd8));
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= FIRST_ADDR;
            r_shadow   <= '0;
            r_byte_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == NEXT) && (w_next_state == IDLE);
            if (r_state == LOAD) begin
                r_shadow   <= rf_data;
                r_byte_idx <= '0;
            end else if (w_ser_load) begin
                r_byte_idx <= w_load_idx;
            end
            if (r_state == NEXT)
                r_addr <= (r_addr < LAST_ADDR) ? r_addr + 4'd1 : FIRST_ADDR;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk         (clk),
        .rst         (rst),
        .i_state     (r_state),
        .i_data      (w_load_byte),
        .i_load      (w_ser_load),
        .o_tx        (tx),
        .o_bit_end   (w_bit_end),
        .o_last_bit  (w_last_bit),
        .o_byte_done (w_byte_done)
    );

    assign rf_addr = r_addr;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;

endmodule
